// File: rtl/mod_clkgen_multiphase_pkg.sv
// mod_clkgen_pkg: shared sizing, clamp limits, config struct and period/quantum helper for the multiphase clock generator.
package mod_clkgen_pkg;
  localparam int CNT_W   = 17;
  localparam int PHASE_W = 5;
  localparam int DUTY_W  = 4;
  localparam int FS_W    = 3;
  localparam int N_CH    = 2;
  localparam int FS_MAX  = CNT_W - PHASE_W;
  localparam int DMAX    = (2 ** PHASE_W) / N_CH - 2;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic [FS_W-1:0]    fs;
    logic [PHASE_W-1:0] phase;
    logic [DUTY_W-1:0]  duty;
  } cfg_t;
  typedef struct packed {
    cnt_t p_mask;
    cnt_t q;
  } period_t;
  // P is a power of two, so P-1 doubles as the modulo mask and Q = P >> PHASE_W.
  function automatic period_t period_of(logic [FS_W-1:0] fs);
    period_t r;
    r.p_mask = {CNT_W{1'b1}} >> fs;
    r.q = (r.p_mask >> PHASE_W) + cnt_t'(1);
    return r;
  endfunction
endpackage

// File: rtl/mod_clkgen_multiphase_if.sv
// mod_clkgen_multiphase_if: control inputs from the register bank and modulation outputs to the drivers.
interface mod_clkgen_multiphase_if;
  import mod_clkgen_pkg::*;
  logic               DRAIN_B;
  logic [FS_W-1:0]    FREQ_SEL;
  logic [PHASE_W-1:0] PHASE_SEL;
  logic [DUTY_W-1:0]  DUTY_SEL;
  logic [N_CH-1:0]    CLK_OUT_MOD;
  logic               CLK_OUT_MODL;
  logic               CYCLE_START;
  modport master (output DRAIN_B, FREQ_SEL, PHASE_SEL, DUTY_SEL,
                  input  CLK_OUT_MOD, CLK_OUT_MODL, CYCLE_START);
  modport slave  (input  DRAIN_B, FREQ_SEL, PHASE_SEL, DUTY_SEL,
                  output CLK_OUT_MOD, CLK_OUT_MODL, CYCLE_START);
endinterface

// File: rtl/mod_window_cmp.sv
// mod_window_cmp: one channel's modular window compare with a registered, drain-parked active-low output.
module mod_window_cmp
  import mod_clkgen_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  cnt_t i_cnt,
  input  cnt_t i_mask,
  input  cnt_t i_start,
  input  cnt_t i_len,
  output logic o_mod
);
  cnt_t w_diff;
  logic r_mod;
  assign w_diff = (i_cnt - i_start) & i_mask;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_mod <= 1'b1;
    else          r_mod <= !(i_run && w_diff < i_len);
  assign o_mod = r_mod;
endmodule

// File: rtl/mod_clkgen_multiphase.sv
// mod_clkgen_multiphase: N_CH evenly spaced non-overlapping active-low modulation windows plus MODL and cycle-start strobe.
module mod_clkgen_multiphase
  import mod_clkgen_pkg::*;
(
  input logic CLK_IN,
  input logic RST_B,
  mod_clkgen_multiphase_if.slave bus
);
  cfg_t            r_cfg, w_cfg_in;
  cnt_t            r_cnt, w_slot, w_base, w_len;
  period_t         w_per;
  logic            w_wrap, w_load, r_modl, r_cs;
  logic [N_CH-1:0] w_mod;
  assign w_per  = period_of(r_cfg.fs);
  assign w_wrap = r_cnt == w_per.p_mask;
  assign w_load = w_wrap || !bus.DRAIN_B;
  assign w_slot = (w_per.p_mask >> $clog2(N_CH)) + cnt_t'(1);
  assign w_base = cnt_t'(r_cfg.phase) * w_per.q;
  assign w_len  = (cnt_t'(r_cfg.duty) + cnt_t'(1)) * w_per.q;
  assign w_cfg_in.fs    = (int'(bus.FREQ_SEL) > FS_MAX) ? FS_W'(FS_MAX) : bus.FREQ_SEL;
  assign w_cfg_in.phase = bus.PHASE_SEL;
  assign w_cfg_in.duty  = (bus.DUTY_SEL > DUTY_W'(DMAX)) ? DUTY_W'(DMAX) : bus.DUTY_SEL;
  // Settings only change at the wrap or while drained, so a period never sees a runt window.
  always_ff @(posedge CLK_IN or negedge RST_B)
    if (!RST_B) begin
      r_cnt  <= '0;
      r_cfg  <= '0;
      r_modl <= 1'b0;
      r_cs   <= 1'b0;
    end else begin
      r_cnt  <= w_load ? '0 : r_cnt + cnt_t'(1);
      if (w_load) r_cfg <= w_cfg_in;
      r_modl <= bus.DRAIN_B && r_cnt <= (w_per.p_mask >> 1);
      r_cs   <= bus.DRAIN_B && r_cnt == '0;
    end
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    mod_window_cmp u_cmp (
      .i_clk   (CLK_IN),
      .i_rst_n (RST_B),
      .i_run   (bus.DRAIN_B),
      .i_cnt   (r_cnt),
      .i_mask  (w_per.p_mask),
      .i_start (w_base + w_slot * cnt_t'(k)),
      .i_len   (w_len),
      .o_mod   (w_mod[k])
    );
  end
  assign bus.CLK_OUT_MOD  = w_mod;
  assign bus.CLK_OUT_MODL = r_modl;
  assign bus.CYCLE_START  = r_cs;
endmodule

// File: tb/tb_mod_clkgen_multiphase.sv
// tb_mod_clkgen_multiphase: directed checks of windows, clamps, wrap, reconfiguration, drain and async reset at FREQ_SEL=4.
module tb_mod_clkgen_multiphase;
  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  int         checks = 0;
  int         errors = 0;
  int         rc = 0;
  logic [3:0] o;
  mod_clkgen_multiphase_if bus();
  mod_clkgen_multiphase dut (.CLK_IN(clk), .RST_B(rst_b), .bus(bus.slave));
  always #5 clk = ~clk;
  // o = {ch1, ch0, MODL, CYCLE_START}; rc is the counter value the outputs currently reflect
  assign o = {bus.CLK_OUT_MOD, bus.CLK_OUT_MODL, bus.CYCLE_START};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      tick();
      rc = (rc + 1) % 8192;
    end
  endtask

  task automatic adv_to(input int t);
    for (int i = 0; i < 8192 && rc != t; i++) adv(1);
  endtask

  task automatic start(input logic [4:0] ph, input logic [3:0] du);
    bus.FREQ_SEL = 3'd4;
    bus.PHASE_SEL = ph;
    bus.DUTY_SEL = du;
    bus.DRAIN_B = 1'b0;
    tick();
    tick();
    checks++; if (o !== 4'b1100) begin errors++; $display("FAIL start_parked got %b exp %b", o, 4'b1100); end
    bus.DRAIN_B = 1'b1;
    tick();
    rc = 0;
  endtask

  task automatic test_reset();
    bus.DRAIN_B = 1'b1;
    bus.FREQ_SEL = '0;
    bus.PHASE_SEL = '0;
    bus.DUTY_SEL = '0;
    #2 rst_b = 1'b0;
    tick();
    tick();
    checks++; if (o !== 4'b1100) begin errors++; $display("FAIL reset_vals got %b exp %b", o, 4'b1100); end
    rst_b = 1'b1;
    tick();
    checks++; if (o !== 4'b1011) begin errors++; $display("FAIL reset_first got %b exp %b", o, 4'b1011); end
  endtask

  task automatic test_windows();
    start(5'd2, 4'd3);
    checks++; if (o !== 4'b1111) begin errors++; $display("FAIL t1_rc0 got %b exp %b", o, 4'b1111); end
    adv(1);
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t1_rc1 got %b exp %b", o, 4'b1110); end
    adv_to(511);
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t1_rc511 got %b exp %b", o, 4'b1110); end
    adv(1);
    checks++; if (o !== 4'b1010) begin errors++; $display("FAIL t1_rc512 got %b exp %b", o, 4'b1010); end
    adv_to(1535);
    checks++; if (o !== 4'b1010) begin errors++; $display("FAIL t1_rc1535 got %b exp %b", o, 4'b1010); end
    adv(1);
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t1_rc1536 got %b exp %b", o, 4'b1110); end
    adv_to(4095);
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t1_rc4095 got %b exp %b", o, 4'b1110); end
    adv(1);
    checks++; if (o !== 4'b1100) begin errors++; $display("FAIL t1_rc4096 got %b exp %b", o, 4'b1100); end
    adv_to(4608);
    checks++; if (o !== 4'b0100) begin errors++; $display("FAIL t1_rc4608 got %b exp %b", o, 4'b0100); end
    adv_to(5631);
    checks++; if (o !== 4'b0100) begin errors++; $display("FAIL t1_rc5631 got %b exp %b", o, 4'b0100); end
    adv(1);
    checks++; if (o !== 4'b1100) begin errors++; $display("FAIL t1_rc5632 got %b exp %b", o, 4'b1100); end
    adv_to(8191);
    checks++; if (o !== 4'b1100) begin errors++; $display("FAIL t1_rc8191 got %b exp %b", o, 4'b1100); end
    adv(1);
    checks++; if (o !== 4'b1111) begin errors++; $display("FAIL t1_next_start got %b exp %b", o, 4'b1111); end
  endtask

  task automatic test_duty_clamp();
    int n0, n1, ov, rise, fall;
    logic [1:0] pm;
    start(5'd0, 4'd15);
    checks++; if (o !== 4'b1011) begin errors++; $display("FAIL t2_rc0 got %b exp %b", o, 4'b1011); end
    n0 = 0; n1 = 0; ov = 0; rise = -1; fall = -1;
    pm = bus.CLK_OUT_MOD;
    for (int i = 0; i < 8192; i++) begin
      if (i > 0) adv(1);
      if (!bus.CLK_OUT_MOD[0]) n0++;
      if (!bus.CLK_OUT_MOD[1]) n1++;
      if (bus.CLK_OUT_MOD == 2'b00) ov++;
      if (i > 0 && bus.CLK_OUT_MOD[0] && !pm[0]) rise = rc;
      if (i > 0 && !bus.CLK_OUT_MOD[1] && pm[1]) fall = rc;
      pm = bus.CLK_OUT_MOD;
    end
    checks++; if (n0 !== 3840) begin errors++; $display("FAIL t2_ch0_len got %0d exp %0d", n0, 3840); end
    checks++; if (n1 !== 3840) begin errors++; $display("FAIL t2_ch1_len got %0d exp %0d", n1, 3840); end
    checks++; if (fall - rise !== 256) begin errors++; $display("FAIL t2_dead_time got %0d exp %0d", fall - rise, 256); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL t2_overlap got %0d exp %0d", ov, 0); end
  endtask

  task automatic test_phase_wrap();
    start(5'd31, 4'd3);
    checks++; if (o !== 4'b1011) begin errors++; $display("FAIL t3_rc0 got %b exp %b", o, 4'b1011); end
    adv_to(767);
    checks++; if (o !== 4'b1010) begin errors++; $display("FAIL t3_rc767 got %b exp %b", o, 4'b1010); end
    adv(1);
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t3_rc768 got %b exp %b", o, 4'b1110); end
    adv_to(3840);
    checks++; if (o !== 4'b0110) begin errors++; $display("FAIL t3_rc3840 got %b exp %b", o, 4'b0110); end
    adv_to(7935);
    checks++; if (o !== 4'b1100) begin errors++; $display("FAIL t3_rc7935 got %b exp %b", o, 4'b1100); end
    adv(1);
    checks++; if (o !== 4'b1000) begin errors++; $display("FAIL t3_rc7936 got %b exp %b", o, 4'b1000); end
    adv_to(8191);
    checks++; if (o !== 4'b1000) begin errors++; $display("FAIL t3_rc8191 got %b exp %b", o, 4'b1000); end
    adv(1);
    checks++; if (o !== 4'b1011) begin errors++; $display("FAIL t3_wrap got %b exp %b", o, 4'b1011); end
  endtask

  task automatic test_reconfig();
    start(5'd2, 4'd3);
    adv_to(1000);
    checks++; if (o !== 4'b1010) begin errors++; $display("FAIL t4_rc1000 got %b exp %b", o, 4'b1010); end
    bus.PHASE_SEL = 5'd10;
    adv_to(1535);
    checks++; if (o !== 4'b1010) begin errors++; $display("FAIL t4_old_rc1535 got %b exp %b", o, 4'b1010); end
    adv(1);
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t4_old_rc1536 got %b exp %b", o, 4'b1110); end
    adv_to(2560);
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t4_old_rc2560 got %b exp %b", o, 4'b1110); end
    adv_to(4608);
    checks++; if (o !== 4'b0100) begin errors++; $display("FAIL t4_old_rc4608 got %b exp %b", o, 4'b0100); end
    adv_to(8191);
    adv(1);
    checks++; if (o !== 4'b1111) begin errors++; $display("FAIL t4_new_rc0 got %b exp %b", o, 4'b1111); end
    adv_to(512);
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t4_new_rc512 got %b exp %b", o, 4'b1110); end
    adv_to(2560);
    checks++; if (o !== 4'b1010) begin errors++; $display("FAIL t4_new_rc2560 got %b exp %b", o, 4'b1010); end
    adv_to(3583);
    checks++; if (o !== 4'b1010) begin errors++; $display("FAIL t4_new_rc3583 got %b exp %b", o, 4'b1010); end
    adv(1);
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t4_new_rc3584 got %b exp %b", o, 4'b1110); end
    adv_to(6656);
    checks++; if (o !== 4'b0100) begin errors++; $display("FAIL t4_new_rc6656 got %b exp %b", o, 4'b0100); end
  endtask

  task automatic test_drain();
    start(5'd2, 4'd3);
    adv_to(600);
    checks++; if (o !== 4'b1010) begin errors++; $display("FAIL t5_rc600 got %b exp %b", o, 4'b1010); end
    bus.DRAIN_B = 1'b0;
    bus.PHASE_SEL = 5'd0;
    bus.DUTY_SEL = 4'd0;
    tick();
    checks++; if (o !== 4'b1100) begin errors++; $display("FAIL t5_parked got %b exp %b", o, 4'b1100); end
    tick();
    checks++; if (o !== 4'b1100) begin errors++; $display("FAIL t5_held got %b exp %b", o, 4'b1100); end
    bus.DRAIN_B = 1'b1;
    tick();
    rc = 0;
    checks++; if (o !== 4'b1011) begin errors++; $display("FAIL t5_release got %b exp %b", o, 4'b1011); end
    adv(1);
    checks++; if (o !== 4'b1010) begin errors++; $display("FAIL t5_rc1 got %b exp %b", o, 4'b1010); end
    adv_to(255);
    checks++; if (o !== 4'b1010) begin errors++; $display("FAIL t5_rc255 got %b exp %b", o, 4'b1010); end
    adv(1);
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t5_rc256 got %b exp %b", o, 4'b1110); end
    adv_to(4096);
    checks++; if (o !== 4'b0100) begin errors++; $display("FAIL t5_rc4096 got %b exp %b", o, 4'b0100); end
  endtask

  task automatic test_async_reset();
    start(5'd2, 4'd3);
    adv_to(3000);
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t6_rc3000 got %b exp %b", o, 4'b1110); end
    bus.FREQ_SEL = 3'd0;
    #2 rst_b = 1'b0;
    #1;
    checks++; if (o !== 4'b1100) begin errors++; $display("FAIL t6_async got %b exp %b", o, 4'b1100); end
    @(posedge clk);
    @(posedge clk);
    #3 rst_b = 1'b1;
    tick();
    checks++; if (o !== 4'b1011) begin errors++; $display("FAIL t6_restart got %b exp %b", o, 4'b1011); end
    repeat (4095) tick();
    checks++; if (o !== 4'b1010) begin errors++; $display("FAIL t6_cnt4095 got %b exp %b", o, 4'b1010); end
    tick();
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t6_cnt4096 got %b exp %b", o, 4'b1110); end
    repeat (4096) tick();
    checks++; if (o !== 4'b1110) begin errors++; $display("FAIL t6_cnt8192 got %b exp %b", o, 4'b1110); end
  endtask

  initial begin
    test_reset();
    test_windows();
    test_duty_clamp();
    test_phase_wrap();
    test_reconfig();
    test_drain();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
